// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches from instruction memory, applies the decoded
// flow op (sequential / jump / conditional branch / halt) and counts redirects.
module pc_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        fetch_req,
    output logic [11:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic        dec_valid,
    input  logic [1:0]  op,
    input  logic [11:0] immd,
    input  logic        flag,
    input  logic        resume,
    output logic        taken,
    output logic        halted,
    output logic [7:0]  taken_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        WAIT_DEC = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [1:0] OP_SEQ    = 2'b00;
    localparam logic [1:0] OP_JUMP   = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic        taken_q, taken_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] seqPc, targetPc;

    // Offsets are unsigned; the 12-bit sum wraps, which is how backward targets are reached.
    assign seqPc    = pc_q + 12'd1;
    assign targetPc = pc_q + immd + 12'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (fetch_ack) state_d = WAIT_DEC;
            end
            WAIT_DEC: begin
                if (dec_valid) begin
                    state_d = FETCH;
                    case (op)
                        OP_SEQ:    pc_d = seqPc;
                        OP_JUMP: begin
                            pc_d    = targetPc;
                            taken_d = 1'b1;
                        end
                        OP_BRANCH: begin
                            pc_d    = flag ? targetPc : seqPc;
                            taken_d = flag;
                        end
                        default:   state_d = HALT;
                    endcase
                end
            end
            HALT: begin
                if (resume) begin
                    pc_d    = seqPc;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (taken_d && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= 12'h000;
            taken_q <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    // Decoded straight from the state register so reset drops them without a clock edge.
    assign fetch_req  = (state_q == FETCH);
    assign halted     = (state_q == HALT);
    assign fetch_addr = pc_q;
    assign taken      = taken_q;
    assign taken_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: walks the fetch/decode flow, wrap, halt,
// stalled ack, asynchronous reset and counter saturation with fixed expectations.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        fetch_req;
    logic [11:0] fetch_addr;
    logic        fetch_ack;
    logic        dec_valid;
    logic [1:0]  op;
    logic [11:0] immd;
    logic        flag;
    logic        resume;
    logic        taken;
    logic        halted;
    logic [7:0]  taken_cnt;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .dec_valid  (dec_valid),
        .op         (op),
        .immd       (immd),
        .flag       (flag),
        .resume     (resume),
        .taken      (taken),
        .halted     (halted),
        .taken_cnt  (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] opV, input logic [11:0] immdV, input logic flagV,
                                 input logic expReq, input logic [11:0] expAddr, input logic expTaken,
                                 input logic [7:0] expCnt, input logic expHalted);
        dec_valid = 1'b1;
        op        = opV;
        immd      = immdV;
        flag      = flagV;
        stepCycle();
        dec_valid = 1'b0;
        op        = 2'b00;
        immd      = 12'h000;
        flag      = 1'b0;
        checkOutput("dec_fetch_req", 32'(fetch_req), 32'(expReq));
        checkOutput("dec_fetch_addr", 32'(fetch_addr), 32'(expAddr));
        checkOutput("dec_taken", 32'(taken), 32'(expTaken));
        checkOutput("dec_taken_cnt", 32'(taken_cnt), 32'(expCnt));
        checkOutput("dec_halted", 32'(halted), 32'(expHalted));
    endtask

    task automatic doAck();
        fetch_ack = 1'b1;
        stepCycle();
        fetch_ack = 1'b0;
        checkOutput("ack_fetch_req", 32'(fetch_req), 32'd0);
        checkOutput("ack_taken_low", 32'(taken), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        fetch_ack = 1'b0;
        dec_valid = 1'b0;
        op        = 2'b00;
        immd      = 12'h000;
        flag      = 1'b0;
        resume    = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_fetch_req", 32'(fetch_req), 32'd0);
        checkOutput("rst_fetch_addr", 32'(fetch_addr), 32'h000);
        checkOutput("rst_taken", 32'(taken), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_taken_cnt", 32'(taken_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle ignores everything except start.
        fetch_ack = 1'b1;
        dec_valid = 1'b1;
        resume    = 1'b1;
        stepCycle();
        stepCycle();
        fetch_ack = 1'b0;
        dec_valid = 1'b0;
        resume    = 1'b0;
        checkOutput("idle_fetch_req", 32'(fetch_req), 32'd0);
        checkOutput("idle_fetch_addr", 32'(fetch_addr), 32'h000);

        start = 1'b1;
        stepCycle();
        start = 1'b0;
        checkOutput("start_fetch_req", 32'(fetch_req), 32'd1);
        checkOutput("start_fetch_addr", 32'(fetch_addr), 32'h000);

        // Three sequential ops, then continue sequentially up to 0x010.
        for (int i = 1; i <= 16; i++) begin
            doAck();
            applyStimulus(2'b00, 12'h000, 1'b0, 1'b1, 12'(i), 1'b0, 8'd0, 1'b0);
        end

        // Taken branch, then back to 0x010 with a backward jump, then untaken branch.
        doAck();
        applyStimulus(2'b10, 12'h005, 1'b1, 1'b1, 12'h016, 1'b1, 8'd1, 1'b0);
        doAck();
        applyStimulus(2'b01, 12'hFF9, 1'b0, 1'b1, 12'h010, 1'b1, 8'd2, 1'b0);
        doAck();
        applyStimulus(2'b10, 12'h005, 1'b0, 1'b1, 12'h011, 1'b0, 8'd2, 1'b0);

        // Wrap at the top of the address space, then a backward jump by one.
        doAck();
        applyStimulus(2'b01, 12'hFED, 1'b0, 1'b1, 12'hFFF, 1'b1, 8'd3, 1'b0);
        doAck();
        applyStimulus(2'b00, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 8'd3, 1'b0);
        doAck();
        applyStimulus(2'b01, 12'h004, 1'b0, 1'b1, 12'h005, 1'b1, 8'd4, 1'b0);
        doAck();
        applyStimulus(2'b01, 12'hFFE, 1'b0, 1'b1, 12'h004, 1'b1, 8'd5, 1'b0);
        doAck();
        applyStimulus(2'b01, 12'h01B, 1'b0, 1'b1, 12'h020, 1'b1, 8'd6, 1'b0);

        // Halt holds pc and ignores stray handshakes until resume.
        doAck();
        applyStimulus(2'b11, 12'h123, 1'b1, 1'b0, 12'h020, 1'b0, 8'd6, 1'b1);
        for (int i = 0; i < 10; i++) begin
            fetch_ack = 1'b1;
            dec_valid = 1'b1;
            op        = 2'b01;
            start     = 1'b1;
            stepCycle();
            checkOutput("halt_halted", 32'(halted), 32'd1);
            checkOutput("halt_fetch_req", 32'(fetch_req), 32'd0);
            checkOutput("halt_fetch_addr", 32'(fetch_addr), 32'h020);
        end
        fetch_ack = 1'b0;
        dec_valid = 1'b0;
        op        = 2'b00;
        start     = 1'b0;
        resume    = 1'b1;
        stepCycle();
        resume    = 1'b0;
        checkOutput("resume_halted", 32'(halted), 32'd0);
        checkOutput("resume_fetch_req", 32'(fetch_req), 32'd1);
        checkOutput("resume_fetch_addr", 32'(fetch_addr), 32'h021);

        // Withheld ack: request and address stay put; stray controls ignored.
        for (int i = 0; i < 5; i++) begin
            dec_valid = 1'b1;
            resume    = 1'b1;
            op        = 2'b01;
            immd      = 12'h0AA;
            stepCycle();
            checkOutput("stall_fetch_req", 32'(fetch_req), 32'd1);
            checkOutput("stall_fetch_addr", 32'(fetch_addr), 32'h021);
        end
        dec_valid = 1'b0;
        resume    = 1'b0;
        op        = 2'b00;
        immd      = 12'h000;
        doAck();
        applyStimulus(2'b00, 12'h000, 1'b0, 1'b1, 12'h022, 1'b0, 8'd6, 1'b0);

        // Asynchronous reset in the middle of FETCH with an ack pending.
        fetch_ack = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_fetch_req", 32'(fetch_req), 32'd0);
        checkOutput("mid_rst_fetch_addr", 32'(fetch_addr), 32'h000);
        checkOutput("mid_rst_taken_cnt", 32'(taken_cnt), 32'd0);
        checkOutput("mid_rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle();
        stepCycle();
        fetch_ack = 1'b0;
        checkOutput("post_rst_idle_req", 32'(fetch_req), 32'd0);
        checkOutput("post_rst_idle_addr", 32'(fetch_addr), 32'h000);

        // 300 redirects: counter must stop at 255.
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        checkOutput("sat_start_req", 32'(fetch_req), 32'd1);
        for (int i = 1; i <= 300; i++) begin
            doAck();
            applyStimulus(2'b01, 12'h000, 1'b0, 1'b1, 12'(i), 1'b1, (i > 255) ? 8'd255 : 8'(i), 1'b0);
        end
        doAck();
        checkOutput("sat_final_cnt", 32'(taken_cnt), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1 bit, begin fetching from IDLE.
REQ-004 SHALL have port fetch_req, output, 1 bit, instruction-fetch request to instruction memory.
REQ-005 SHALL have port fetch_addr, output, 12 bits, fetch address; always equals the pc register.
REQ-006 SHALL have port fetch_ack, input, 1 bit, memory accepted the request and returned the instruction.
REQ-007 SHALL have port dec_valid, input, 1 bit, decoder presents op/immd/flag for the fetched instruction.
REQ-008 SHALL have port op, input, 2 bits, flow op: 00 sequential, 01 jump, 10 branch-if-flag, 11 halt.
REQ-009 SHALL have port immd, input, 12 bits, branch/jump offset.
REQ-010 SHALL have port flag, input, 1 bit, condition flag from ALU.
REQ-011 SHALL have port resume, input, 1 bit, leave HALT.
REQ-012 SHALL have port taken, output, 1 bit, one-cycle pulse when a jump or branch redirects pc.
REQ-013 SHALL have port halted, output, 1 bit, high while in HALT.
REQ-014 SHALL have port taken_cnt, output, 8 bits, count of redirects, saturating.

Function
REQ-015 SHALL implement states IDLE, FETCH, WAIT_DEC, HALT.
REQ-016 IDLE: fetch_req=0; start=1 moves to FETCH next cycle; other inputs ignored.
REQ-017 FETCH: fetch_req=1, fetch_addr held stable until fetch_ack; fetch_ack=1 moves to WAIT_DEC; no timeout.
REQ-018 WAIT_DEC: fetch_req=0; op/immd/flag sampled only in the cycle dec_valid=1; pc updates on that edge.
REQ-019 Next pc for op 00 SHALL be pc+1; for op 01 pc+immd+1; for op 10 pc+immd+1 if flag=1 else pc+1; all modulo 4096 (carry discarded, wrap 0xFFF+1=0x000).
REQ-020 op 00/01/10 with dec_valid SHALL move WAIT_DEC to FETCH; fetch_req rises the following cycle with the new pc.
REQ-021 op 11 with dec_valid SHALL leave pc unchanged and move to HALT.
REQ-022 HALT: halted=1, fetch_req=0; resume=1 sets pc=pc+1 (wrapping) and moves to FETCH.
REQ-023 taken SHALL pulse exactly one cycle after the decision edge for op 01, or op 10 with flag=1; it SHALL be 0 otherwise.
REQ-024 taken_cnt SHALL increment with each taken pulse and hold at 255.
REQ-025 start/resume outside IDLE/HALT, fetch_ack outside FETCH, and dec_valid outside WAIT_DEC SHALL be ignored.
REQ-026 Immediate offset SHALL be treated unsigned; backward branches rely on modulo wrap (immd=0xFFE gives pc-1).

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, pc=0x000, fetch_req=0, taken=0, halted=0, taken_cnt=0, regardless of clk.
REQ-028 Reset asserted mid-FETCH SHALL drop fetch_req asynchronously; the pending ack is discarded.
REQ-029 After rst_n deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-030 Reset, start, ack, dec_valid op=00 three times -> fetch_addr sequence 0x000,0x001,0x002,0x003; taken never high.
REQ-031 pc=0x010, op=10, flag=1, immd=0x005 -> next fetch_addr 0x016, taken pulses once, taken_cnt=1; same with flag=0 -> 0x011, no pulse.
REQ-032 pc=0xFFF, op=00 -> fetch_addr 0x000; pc=0x005, op=01, immd=0xFFE -> fetch_addr 0x004.
REQ-033 op=11 at pc=0x020 -> halted=1, fetch_req=0 for 10 cycles; resume -> fetch_addr 0x021, halted=0.
REQ-034 fetch_ack withheld 5 cycles -> fetch_req and fetch_addr stable throughout; rst_n pulled low mid-FETCH -> fetch_req=0 and pc=0x000 without a clock edge.
REQ-035 300 taken jumps -> taken_cnt saturates at 255.
